// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port register file slice.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: flush > issue set > write clear per entry, per-port lookup.
// Latency: busy updates visible one edge after issue/write/flush; lookup combinational (REGFILE_BYPASS_EN masks forwarded ports).
// Backpressure: none, always accepts issue/write/flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    input  logic                    flush,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD-1:0]        rbusy
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;

    // Issue is written after the write clear so a same-cycle newer producer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (we && waddr != ADDR_W'(REG_ZERO))
                busy[waddr] <= 1'b0;
            if (iss_valid && iss_rd != ADDR_W'(REG_ZERO))
                busy[iss_rd] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_lookup
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rbusy[i] = (ra != ADDR_W'(REG_ZERO)) && busy[ra] && !(we && ra == waddr);
`else
        assign rbusy[i] = (ra != ADDR_W'(REG_ZERO)) && busy[ra];
`endif
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard; x0 hardwired to zero.
// Latency: reads combinational; write visible next cycle, or same cycle when REGFILE_BYPASS_EN is defined.
// Backpressure: none, all ports are always ready.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    input  logic                    flush
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else if (we && waddr != ADDR_W'(REG_ZERO)) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rdata[i*DATA_W +: DATA_W] = (ra == ADDR_W'(REG_ZERO)) ? '0 :
                                           (we && ra == waddr)       ? wdata : mem[ra];
`else
        assign rdata[i*DATA_W +: DATA_W] = (ra == ADDR_W'(REG_ZERO)) ? '0 : mem[ra];
`endif
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .raddr     (raddr),
        .rbusy     (rbusy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a 3-port/16-bit/16-entry instance.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration instance
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_we, a_iss_valid, a_flush;
    logic [4:0]  a_waddr, a_iss_rd;
    logic [31:0] a_wdata;

    regfile_mp u_dut_a (
        .clk (clk), .rst (rst), .raddr (a_raddr), .rdata (a_rdata), .rbusy (a_rbusy),
        .we (a_we), .waddr (a_waddr), .wdata (a_wdata),
        .iss_valid (a_iss_valid), .iss_rd (a_iss_rd), .flush (a_flush)
    );

    // Narrow configuration instance
    logic [11:0] b_raddr;
    logic [47:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic        b_we, b_iss_valid, b_flush;
    logic [3:0]  b_waddr, b_iss_rd;
    logic [15:0] b_wdata;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NREAD(3)) u_dut_b (
        .clk (clk), .rst (rst), .raddr (b_raddr), .rdata (b_rdata), .rbusy (b_rbusy),
        .we (b_we), .waddr (b_waddr), .wdata (b_wdata),
        .iss_valid (b_iss_valid), .iss_rd (b_iss_rd), .flush (b_flush)
    );

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_raddr = '0; a_we = 0; a_waddr = '0; a_wdata = '0;
        a_iss_valid = 0; a_iss_rd = '0; a_flush = 0;
        b_raddr = '0; b_we = 0; b_waddr = '0; b_wdata = '0;
        b_iss_valid = 0; b_iss_rd = '0; b_flush = 0;

        // Reset state
        tick(); tick();
        a_raddr = {5'd3, 5'd5};
        #1;
        check("reset_rdata", {32'h0, a_rdata}, 64'h0);
        check("reset_rbusy", {62'h0, a_rbusy}, 64'h0);
        rst = 1'b0;

        // Write x3, read same cycle and next cycle
        a_we = 1; a_waddr = 5'd3; a_wdata = 32'h1234_5678; a_raddr = {5'd0, 5'd3};
        #1;
        check("wr_same_cycle", {32'h0, a_rdata[31:0]}, BYP ? 64'h1234_5678 : 64'h0);
        tick();
        a_we = 0;
        #1;
        check("wr_next_cycle", {32'h0, a_rdata[31:0]}, 64'h1234_5678);
        check("rd_port1_x0", {32'h0, a_rdata[63:32]}, 64'h0);

        // x0 write and issue ignored
        a_we = 1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
        a_iss_valid = 1; a_iss_rd = 5'd0; a_raddr = {5'd0, 5'd0};
        tick();
        a_we = 0; a_iss_valid = 0;
        #1;
        check("x0_rdata", {32'h0, a_rdata[31:0]}, 64'h0);
        check("x0_rbusy", {62'h0, a_rbusy}, 64'h0);

        // Issue x7 then write it back
        a_iss_valid = 1; a_iss_rd = 5'd7; a_raddr = {5'd0, 5'd7};
        #1;
        check("iss_before_edge", {63'h0, a_rbusy[0]}, 64'h0);
        tick();
        a_iss_valid = 0;
        #1;
        check("iss_busy_set", {63'h0, a_rbusy[0]}, 64'h1);
        a_we = 1; a_waddr = 5'd7; a_wdata = 32'h55;
        #1;
        check("wb_busy_same", {63'h0, a_rbusy[0]}, BYP ? 64'h0 : 64'h1);
        check("wb_data_same", {32'h0, a_rdata[31:0]}, BYP ? 64'h55 : 64'h0);
        tick();
        a_we = 0;
        #1;
        check("wb_busy_clear", {63'h0, a_rbusy[0]}, 64'h0);
        check("wb_data_x7", {32'h0, a_rdata[31:0]}, 64'h55);

        // Issue and write the same register in one cycle
        a_iss_valid = 1; a_iss_rd = 5'd9; a_we = 1; a_waddr = 5'd9; a_wdata = 32'hAA;
        a_raddr = {5'd9, 5'd9};
        tick();
        a_iss_valid = 0; a_we = 0;
        #1;
        check("coll_data_p0", {32'h0, a_rdata[31:0]}, 64'hAA);
        check("coll_data_p1", {32'h0, a_rdata[63:32]}, 64'hAA);
        check("coll_busy", {62'h0, a_rbusy}, 64'h3);

        // Flush with coincident issue of x10 and write of x11
        a_flush = 1; a_iss_valid = 1; a_iss_rd = 5'd10;
        a_we = 1; a_waddr = 5'd11; a_wdata = 32'h1111_0000;
        tick();
        a_flush = 0; a_iss_valid = 0; a_we = 0;
        a_raddr = {5'd10, 5'd9};
        #1;
        check("flush_busy", {62'h0, a_rbusy}, 64'h0);
        a_raddr = {5'd0, 5'd11};
        #1;
        check("flush_write", {32'h0, a_rdata[31:0]}, 64'h1111_0000);

        // Mid-run reset overrides pending write and clears busy
        a_we = 1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        a_iss_valid = 1; a_iss_rd = 5'd12; a_raddr = {5'd12, 5'd5};
        tick();
        a_iss_valid = 0;
        a_waddr = 5'd6; a_wdata = 32'h1;
        #1;
        check("pre_rst_x5", {32'h0, a_rdata[31:0]}, 64'hDEAD_BEEF);
        check("pre_rst_busy12", {63'h0, a_rbusy[1]}, 64'h1);
        rst = 1;
        #1;
        check("rst_rdata", {32'h0, a_rdata}, 64'h0);
        check("rst_rbusy", {62'h0, a_rbusy}, 64'h0);
        tick();
        a_we = 0;
        rst = 0;
        a_raddr = {5'd6, 5'd5};
        #1;
        check("post_rst_x5", {32'h0, a_rdata[31:0]}, 64'h0);
        check("post_rst_x6", {32'h0, a_rdata[63:32]}, 64'h0);

        // Narrow instance: three independent ports
        b_we = 1; b_waddr = 4'd1; b_wdata = 16'h1111;
        tick();
        b_waddr = 4'd2; b_wdata = 16'h2222;
        tick();
        b_waddr = 4'd15; b_wdata = 16'hBEEF;
        b_iss_valid = 1; b_iss_rd = 4'd2;
        tick();
        b_we = 0; b_iss_valid = 0;
        b_raddr = {4'd15, 4'd2, 4'd1};
        #1;
        check("b_p0_x1", {48'h0, b_rdata[15:0]}, 64'h1111);
        check("b_p1_x2", {48'h0, b_rdata[31:16]}, 64'h2222);
        check("b_p2_x15", {48'h0, b_rdata[47:32]}, 64'hBEEF);
        check("b_rbusy", {61'h0, b_rbusy}, 64'h2);
        b_raddr = {4'd1, 4'd15, 4'd15};
        #1;
        check("b_perm", {16'h0, b_rdata}, 64'h1111_BEEF_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
